// File: rtl/sb_color_pkg.sv
// -----------------------------------------------------------------------------
// sb_color_pkg
// Shared definitions for the colour-sensor emulator:
//   - filter codes ({S2,S3} and cfg_sel encoding)
//   - frequency-scale codes ({S0,S1}) and their phase-length multipliers
//   - FSM state encodings
// -----------------------------------------------------------------------------
package sb_color_pkg;

   typedef enum logic [1:0] {
      FLT_RED   = 2'b00,
      FLT_BLUE  = 2'b01,
      FLT_CLEAR = 2'b10,
      FLT_GREEN = 2'b11
   } filter_t;

   typedef enum logic [1:0] {
      SCL_OFF    = 2'b00,
      SCL_2PCT   = 2'b01,
      SCL_20PCT  = 2'b10,
      SCL_100PCT = 2'b11
   } scale_t;

   // A lower output-frequency scale stretches every phase by this factor.
   localparam int MULT_2PCT   = 50;
   localparam int MULT_20PCT  = 5;
   localparam int MULT_100PCT = 1;
   localparam int MULT_W      = 6;

   typedef enum logic [1:0] {
      ST_OFF,
      ST_SETTLE,
      ST_LOW,
      ST_HIGH
   } state_t;

   function automatic logic [MULT_W-1:0] scale_mult(input scale_t scale);
      case (scale)
         SCL_2PCT:   return MULT_W'(MULT_2PCT);
         SCL_20PCT:  return MULT_W'(MULT_20PCT);
         SCL_100PCT: return MULT_W'(MULT_100PCT);
         default:    return '0;
      endcase
   endfunction

endpackage

// File: rtl/sb_color_sensor_emulator_if.sv
// -----------------------------------------------------------------------------
// sb_color_sensor_emulator_if
// Sensor-side bus of the emulated colour sensor.
//   S0,S1     frequency scale select        S2,S3     photodiode filter select
//   oe_n      output enable, active-low     cfg_we    half-period write strobe
//   cfg_sel   register select ({S2,S3} code) cfg_data half-period value
//   OUT       square-wave output            pulse_count  rising edges on OUT
// master = sensor driver / bench, slave = emulator.
// -----------------------------------------------------------------------------
interface sb_color_sensor_emulator_if #(
   parameter int HP_W = 16
) ();

   logic            S0;
   logic            S1;
   logic            S2;
   logic            S3;
   logic            oe_n;
   logic            cfg_we;
   logic [1:0]      cfg_sel;
   logic [HP_W-1:0] cfg_data;
   logic            OUT;
   logic [15:0]     pulse_count;

   modport master (
      output S0, S1, S2, S3, oe_n, cfg_we, cfg_sel, cfg_data,
      input  OUT, pulse_count
   );

   modport slave (
      input  S0, S1, S2, S3, oe_n, cfg_we, cfg_sel, cfg_data,
      output OUT, pulse_count
   );

endinterface

// File: rtl/sb_phase_timer.sv
// -----------------------------------------------------------------------------
// sb_phase_timer
// Loadable down-counter that times SETTLE and OUT phases.
//   clk_50    clock                      rst       synchronous reset, active-high
//   load      load load_val (wins over en)
//   en        decrement by one, saturating at zero
//   load_val  value to load              zero      counter is at zero
// -----------------------------------------------------------------------------
module sb_phase_timer #(
   parameter int W = 22
) (
   input  logic         clk_50,
   input  logic         rst,
   input  logic         load,
   input  logic         en,
   input  logic [W-1:0] load_val,
   output logic         zero
);

   logic [W-1:0] cnt;

   always_ff @(posedge clk_50) begin
      if (rst) begin
         cnt <= '0;
      end else if (load) begin
         cnt <= load_val;
      end else if (en && (cnt != '0)) begin
         cnt <= cnt - W'(1);
      end
   end

   assign zero = (cnt == '0);

endmodule

// File: rtl/sb_color_sensor_emulator.sv
// -----------------------------------------------------------------------------
// sb_color_sensor_emulator
// Sensor side of a TCS3200-class colour sensor. Emits a 50% duty square wave on
// OUT whose half-period is hp[filter] * scale multiplier clk_50 cycles, holds OUT
// low for SETTLE cycles after any S0..S3 change, and counts rising edges.
//   clk_50  50 MHz clock
//   rst     synchronous reset, active-high
//   bus     slave side of sb_color_sensor_emulator_if (S0..S3, oe_n, cfg_*,
//           OUT, pulse_count)
// -----------------------------------------------------------------------------
module sb_color_sensor_emulator
   import sb_color_pkg::*;
#(
   parameter int HP_W      = 16,
   parameter int SETTLE    = 64,
   parameter int DEF_RED   = 2000,
   parameter int DEF_BLUE  = 2000,
   parameter int DEF_CLEAR = 1000,
   parameter int DEF_GREEN = 2000
) (
   input  logic                        clk_50,
   input  logic                        rst,
   sb_color_sensor_emulator_if.slave   bus
);

   localparam int CW = HP_W + MULT_W;

   logic [3:0]      s_in;
   logic [3:0]      s_q;
   scale_t          scale_q;
   filter_t         filter_q;
   logic            force_off;
   logic            s_changed;
   logic [HP_W-1:0] hp [4];
   logic [HP_W-1:0] hp_eff;
   logic [CW-1:0]   len;
   state_t          state;
   state_t          state_nxt;
   logic            tmr_load;
   logic            tmr_en;
   logic            tmr_zero;
   logic [CW-1:0]   tmr_val;
   logic            out_d;
   logic            rise;
   logic            out_q;
   logic [15:0]     pulse_q;

   assign s_in      = {bus.S0, bus.S1, bus.S2, bus.S3};
   assign scale_q   = scale_t'(s_q[3:2]);
   assign filter_q  = filter_t'(s_q[1:0]);
   assign force_off = (s_in[3:2] == SCL_OFF) || bus.oe_n;
   assign s_changed = (s_in != s_q);

   // The select register tracks the pins every cycle, reset included, so that
   // leaving reset with stable pins is not mistaken for a select change.
   // NOTE: sequential state uses non-blocking assignments so every flop samples
   // pre-edge values regardless of process evaluation order.
   always_ff @(posedge clk_50) begin
      s_q <= s_in;
   end

   // NOTE: the four half-period registers are reset because they must come up
   // holding the DEF_* values; this is a tiny flop file, not a RAM.
   always_ff @(posedge clk_50) begin
      if (rst) begin
         hp[FLT_RED]   <= HP_W'(DEF_RED);
         hp[FLT_BLUE]  <= HP_W'(DEF_BLUE);
         hp[FLT_CLEAR] <= HP_W'(DEF_CLEAR);
         hp[FLT_GREEN] <= HP_W'(DEF_GREEN);
      end else if (bus.cfg_we) begin
         hp[bus.cfg_sel] <= bus.cfg_data;
      end
   end

   // A write to the active filter in the same cycle as a phase load is bypassed
   // so the freshly written value is the one loaded.
   // NOTE: every always_comb output gets a default first so no path leaves it
   // unassigned and infers a latch.
   always_comb begin
      hp_eff = hp[filter_q];
      if (bus.cfg_we && (bus.cfg_sel == filter_q)) begin
         hp_eff = bus.cfg_data;
      end
   end

   // Full-width product: 16-bit half-period times up to 50 needs 22 bits.
   assign len = CW'(hp_eff) * CW'(scale_mult(scale_q));

   sb_phase_timer #(
      .W (CW)
   ) u_timer (
      .clk_50   (clk_50),
      .rst      (rst),
      .load     (tmr_load),
      .en       (tmr_en),
      .load_val (tmr_val),
      .zero     (tmr_zero)
   );

   // State register.
   always_ff @(posedge clk_50) begin
      if (rst) begin
         state <= ST_OFF;
      end else begin
         state <= state_nxt;
      end
   end

   // Next-state and timer control. Power-down/disable beats a select change,
   // which beats the normal phase sequencing.
   always_comb begin
      state_nxt = state;
      tmr_load  = 1'b0;
      tmr_en    = 1'b0;
      tmr_val   = '0;
      if (force_off) begin
         state_nxt = ST_OFF;
      end else if (s_changed || (state == ST_OFF)) begin
         state_nxt = ST_SETTLE;
         tmr_load  = 1'b1;
         tmr_val   = CW'(SETTLE - 1);
      end else if (!tmr_zero) begin
         tmr_en = 1'b1;
      end else begin
         case (state)
            ST_SETTLE: begin
               // A dark channel parks here with the counter at zero until a
               // non-zero half-period is written.
               if (len != '0) begin
                  state_nxt = ST_LOW;
                  tmr_load  = 1'b1;
                  tmr_val   = len - CW'(1);
               end
            end
            ST_LOW, ST_HIGH: begin
               if (len == '0) begin
                  state_nxt = ST_SETTLE;
                  tmr_load  = 1'b1;
                  tmr_val   = CW'(SETTLE - 1);
               end else begin
                  state_nxt = (state == ST_LOW) ? ST_HIGH : ST_LOW;
                  tmr_load  = 1'b1;
                  tmr_val   = len - CW'(1);
               end
            end
            default: begin
               state_nxt = ST_OFF;
            end
         endcase
      end
   end

   // Output decode: OUT follows the next state so it is driven from a flop.
   always_comb begin
      out_d = (state_nxt == ST_HIGH);
      rise  = out_d && !out_q;
   end

   always_ff @(posedge clk_50) begin
      if (rst) begin
         out_q   <= 1'b0;
         pulse_q <= '0;
      end else begin
         out_q <= out_d;
         if (rise) begin
            pulse_q <= pulse_q + 16'd1;
         end
      end
   end

   assign bus.OUT         = out_q;
   assign bus.pulse_count = pulse_q;

endmodule

// File: tb/tb_sb_color_sensor_emulator.sv
// -----------------------------------------------------------------------------
// tb_sb_color_sensor_emulator
// Directed bench for sb_color_sensor_emulator. A segment model (start edge,
// phase length, pulse base, optional stop edge) predicts OUT and pulse_count
// arithmetically and is compared every cycle; literal latencies and periods
// pin the model.
// -----------------------------------------------------------------------------
module tb_sb_color_sensor_emulator;

   localparam int SETTLE   = 64;
   localparam int CLK_HALF = 10;

   logic clk_50 = 1'b0;
   logic rst    = 1'b1;
   int   cyc    = 0;
   int   n_checks = 0;
   int   n_fail   = 0;

   always #CLK_HALF clk_50 = ~clk_50;
   always @(posedge clk_50) cyc <= cyc + 1;

   sb_color_sensor_emulator_if bus ();

   sb_color_sensor_emulator dut (
      .clk_50 (clk_50),
      .rst    (rst),
      .bus    (bus)
   );

   // Model: OUT low until m_t + SETTLE + m_len, then toggling every m_len edges.
   bit m_valid = 1'b0;
   bit m_on    = 1'b0;
   int m_t     = 0;
   int m_len   = 0;
   int m_base  = 0;
   int m_stop  = -1;
   int hp_m [4];

   function automatic int mult_of(input int s01);
      case (s01)
         1:       return 50;
         2:       return 5;
         3:       return 1;
         default: return 0;
      endcase
   endfunction

   function automatic void model_at(input int k, output int out, output int pc);
      int kk;
      int d;
      int ph;
      out = 0;
      pc  = m_base;
      if (m_on && (m_len > 0)) begin
         kk = ((m_stop >= 0) && (k > m_stop)) ? m_stop : k;
         d  = kk - m_t - SETTLE - m_len;
         if (d >= 0) begin
            ph  = d / m_len;
            out = ((ph % 2) == 0) ? 1 : 0;
            pc  = (m_base + ph / 2 + 1) % 65536;
         end
         if ((m_stop >= 0) && (k > m_stop)) out = 0;
      end
   endfunction

   task automatic check(input string name, input logic [31:0] actual, input logic [31:0] expected);
      n_checks++;
      if (actual !== expected) begin
         n_fail++;
         $display("FAIL %s: actual %0d, expected %0d (cycle %0d)", name, actual, expected, cyc);
      end
   endtask

   // Per-cycle compare against the model.
   always @(posedge clk_50) begin
      int eo;
      int ep;
      #1;
      if (m_valid) begin
         model_at(cyc, eo, ep);
         check("cmp_out", 32'(bus.OUT), eo);
         check("cmp_pulse_count", 32'(bus.pulse_count), ep);
      end
   end

   // Drive pins at a negedge; the change is seen at edge cyc+1.
   task automatic apply(input int s01, input int s23, input int oen);
      int eo;
      int pc;
      model_at(cyc, eo, pc);
      bus.S0   = s01[1];
      bus.S1   = s01[0];
      bus.S2   = s23[1];
      bus.S3   = s23[0];
      bus.oe_n = oen[0];
      m_base   = pc;
      m_stop   = -1;
      if ((s01 == 0) || (oen != 0)) begin
         m_on = 1'b0;
      end else begin
         m_on  = 1'b1;
         m_t   = cyc + 1;
         m_len = hp_m[s23] * mult_of(s01);
      end
   endtask

   task automatic cfg_drive(input int sel, input int val);
      bus.cfg_we   = 1'b1;
      bus.cfg_sel  = sel[1:0];
      bus.cfg_data = val[15:0];
      hp_m[sel]    = val;
   endtask

   task automatic cfg_release();
      @(negedge clk_50);
      bus.cfg_we = 1'b0;
   endtask

   task automatic wait_edge(input logic lvl, input int bound, input string name, output int at);
      logic prev;
      int   n;
      prev = bus.OUT;
      n    = 0;
      at   = -1;
      while ((at < 0) && (n < bound)) begin
         @(posedge clk_50);
         #1;
         n++;
         if ((prev !== lvl) && (bus.OUT === lvl)) at = cyc;
         prev = bus.OUT;
      end
      check({name, "_seen"}, (at >= 0) ? 1 : 0, 1);
   endtask

   initial begin
      #(4_000_000 * CLK_HALF);
      $display("FAIL watchdog: simulation did not finish (cycle %0d)", cyc);
      $fatal(1, "watchdog expired");
   end

   initial begin
      int r1;
      int r2;
      int f1;
      int t;
      int eo;
      int pc;
      int d;
      int f;

      hp_m         = '{2000, 2000, 1000, 2000};
      bus.S0       = 1'b1;
      bus.S1       = 1'b1;
      bus.S2       = 1'b0;
      bus.S3       = 1'b0;
      bus.oe_n     = 1'b0;
      bus.cfg_we   = 1'b0;
      bus.cfg_sel  = 2'b00;
      bus.cfg_data = '0;

      // Reset values.
      repeat (3) @(posedge clk_50);
      #1;
      check("reset_out", 32'(bus.OUT), 0);
      check("reset_pulse_count", 32'(bus.pulse_count), 0);

      // A: defaults, red, x1.
      @(negedge clk_50);
      rst     = 1'b0;
      m_on    = 1'b1;
      m_t     = cyc + 1;
      m_len   = 2000;
      m_base  = 0;
      m_stop  = -1;
      m_valid = 1'b1;
      t       = m_t;
      wait_edge(1'b1, 2200, "a_rise1", r1);
      check("a_first_rise_latency", r1 - t, 2064);
      check("a_pc_after_rise1", 32'(bus.pulse_count), 1);
      wait_edge(1'b0, 2100, "a_fall", f1);
      wait_edge(1'b1, 2100, "a_rise2", r2);
      check("a_high_time", f1 - r1, 2000);
      check("a_period", r2 - r1, 4000);
      check("a_pc_after_rise2", 32'(bus.pulse_count), 2);

      // B: green=100, scale 20%.
      @(negedge clk_50);
      cfg_drive(3, 100);
      cfg_release();
      @(negedge clk_50);
      t = cyc + 1;
      apply(2, 3, 0);
      wait_edge(1'b1, 700, "b_rise1", r1);
      check("b_first_rise_latency", r1 - t, 564);
      wait_edge(1'b1, 1100, "b_rise2", r2);
      check("b_period", r2 - r1, 1000);

      // C: scale 2%.
      @(negedge clk_50);
      t = cyc + 1;
      apply(1, 3, 0);
      wait_edge(1'b1, 5200, "c_rise1", r1);
      check("c_first_rise_latency", r1 - t, 5064);
      wait_edge(1'b1, 10100, "c_rise2", r2);
      check("c_period", r2 - r1, 10000);

      // D: red=100 x1, then switch to clear mid-HIGH.
      @(negedge clk_50);
      cfg_drive(0, 100);
      cfg_release();
      @(negedge clk_50);
      t = cyc + 1;
      apply(3, 0, 0);
      wait_edge(1'b1, 300, "d_rise0", r1);
      check("d_red_latency", r1 - t, 164);
      repeat (30) @(posedge clk_50);
      @(negedge clk_50);
      t = cyc + 1;
      apply(3, 2, 0);
      wait_edge(1'b0, 10, "d_cut_fall", f);
      check("d_cut_fall_edge", f - t, 0);
      wait_edge(1'b1, 1200, "d_rise1", r1);
      check("d_rise_after_cut", r1 - t, 1064);
      check("d_cut_not_counted", 32'(bus.pulse_count), (m_base + 1) % 65536);
      wait_edge(1'b1, 2100, "d_rise2", r2);
      check("d_period", r2 - r1, 2000);

      // E: red=10 running, write red=0 mid-HIGH, then wake with 10.
      @(negedge clk_50);
      cfg_drive(0, 10);
      cfg_release();
      @(negedge clk_50);
      t = cyc + 1;
      apply(3, 0, 0);
      wait_edge(1'b1, 200, "e_rise0", r1);
      check("e_red10_latency", r1 - t, 74);
      repeat (3) @(posedge clk_50);
      @(negedge clk_50);
      d = cyc - m_t - SETTLE - m_len;
      f = m_t + SETTLE + m_len + (d / m_len + 1) * m_len;
      cfg_drive(0, 0);
      m_stop = f;
      cfg_release();
      wait_edge(1'b0, 20, "e_phase_end", f1);
      check("e_phase_end_edge", f1 - r1, 10);
      repeat (200) @(posedge clk_50);
      #1;
      check("e_dark_out", 32'(bus.OUT), 0);
      @(negedge clk_50);
      m_valid = 1'b0;
      model_at(cyc, eo, pc);
      cfg_drive(0, 10);
      cfg_release();
      wait_edge(1'b1, 200, "e_wake_rise", r1);
      m_on    = 1'b1;
      m_len   = 10;
      m_t     = r1 - SETTLE - 10;
      m_base  = pc;
      m_stop  = -1;
      m_valid = 1'b1;
      check("e_wake_pc", 32'(bus.pulse_count), (pc + 1) % 65536);
      wait_edge(1'b1, 40, "e_rise2", r2);
      check("e_period", r2 - r1, 20);

      // F1: oe_n=1 mid-LOW, then release.
      wait_edge(1'b0, 30, "f1_low", f);
      repeat (2) @(posedge clk_50);
      @(negedge clk_50);
      apply(3, 0, 1);
      repeat (50) @(posedge clk_50);
      #1;
      check("f1_oe_out", 32'(bus.OUT), 0);
      @(negedge clk_50);
      t = cyc + 1;
      apply(3, 0, 0);
      wait_edge(1'b1, 200, "f1_rise", r1);
      check("f1_release_latency", r1 - t, 74);

      // F2: S0S1=00 mid-LOW; program green/blue while powered down.
      wait_edge(1'b0, 30, "f2_low", f);
      repeat (2) @(posedge clk_50);
      @(negedge clk_50);
      apply(0, 0, 0);
      repeat (50) @(posedge clk_50);
      #1;
      check("f2_pd_out", 32'(bus.OUT), 0);
      @(negedge clk_50);
      cfg_drive(3, 700);
      @(negedge clk_50);
      cfg_drive(1, 650);
      cfg_release();

      // H: wake to red x1 with a simultaneous red=400 write.
      @(negedge clk_50);
      t = cyc + 1;
      cfg_drive(0, 400);
      apply(3, 0, 0);
      cfg_release();
      wait_edge(1'b1, 600, "h_rise1", r1);
      check("h_first_rise_latency", r1 - t, 464);
      wait_edge(1'b1, 900, "h_rise2", r2);
      check("h_period", r2 - r1, 800);

      // G: reset mid-HIGH, then restart from defaults.
      repeat (3) @(posedge clk_50);
      @(negedge clk_50);
      rst    = 1'b1;
      hp_m   = '{2000, 2000, 1000, 2000};
      m_on   = 1'b0;
      m_base = 0;
      m_stop = -1;
      @(posedge clk_50);
      #1;
      check("g_reset_out", 32'(bus.OUT), 0);
      check("g_reset_pulse_count", 32'(bus.pulse_count), 0);
      repeat (2) @(posedge clk_50);
      @(negedge clk_50);
      rst    = 1'b0;
      m_on   = 1'b1;
      m_t    = cyc + 1;
      m_len  = 2000;
      m_base = 0;
      t      = m_t;
      wait_edge(1'b1, 2200, "g_rise1", r1);
      check("g_first_rise_latency", r1 - t, 2064);
      check("g_pc_after_rise1", 32'(bus.pulse_count), 1);

      repeat (5) @(posedge clk_50);
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
